// File: rtl/prbs_frame_tx.sv
// prbs_frame_tx: framed AXI-Stream test-traffic source driven by a 32-bit Fibonacci LFSR
// (x^32 + x^22 + x^2 + x + 1), DATA_WIDTH/32 lanes per beat.
//
// Optional feature macro: PRBS_FRAME_TX_SEQ_EN
//   defined   -> lane 0 of every SOF beat carries the frame sequence number
//   undefined -> every lane of every beat carries PRBS
//
// The LFSR register always holds the state for the *next* beat to be presented, so a new
// beat can be loaded into the output registers on the same edge that accepts the old one.
module prbs_frame_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [31:0]           i_seed,
    input  logic [LEN_WIDTH-1:0]  i_frame_len,
    input  logic [LEN_WIDTH-1:0]  i_gap,
    input  logic [LEN_WIDTH-1:0]  i_num_frames,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_sof,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_frames_sent
);

    localparam int unsigned LANES = DATA_WIDTH / 32;

    localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    // Lane k of a beat is the LFSR state advanced k steps from s.
    function automatic logic [DATA_WIDTH-1:0] lanes_from(input logic [31:0] s);
        logic [DATA_WIDTH-1:0] res;
        logic [31:0]           t;
        res = '0;
        t   = s;
        for (int unsigned k = 0; k < LANES; k++) begin
            res[32*k +: 32] = t;
            t = lfsr_step(t);
        end
        return res;
    endfunction

    // State that follows a full beat (LANES steps).
    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int unsigned k = 0; k < LANES; k++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    // Registered state and outputs
    state_e                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   gap_q, gap_d;
    logic [LEN_WIDTH-1:0]   num_q, num_d;
    logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LEN_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   tvalid_q, tvalid_d;
    logic                   sof_q, sof_d;
    logic                   tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]   frames_sent_q, frames_sent_d;

    // Beat-generation helpers
    logic                   start_acc;
    logic [31:0]            seed_eff;
    logic [LEN_WIDTH-1:0]   len_in_eff;
    logic [31:0]            lfsr_src;
    logic [LEN_WIDTH-1:0]   len_src;
    logic [DATA_WIDTH-1:0]  beat_lanes;
    logic [31:0]            lfsr_next;
    logic                   last_beat;
    logic                   stop_now;

    // Beat-load control from the FSM
    logic                   load_beat;
    logic [LEN_WIDTH-1:0]   load_idx;
    logic [CNT_WIDTH-1:0]   seq_num;

    // Source of the next beat: the seed on an accepted start, otherwise the running LFSR.
    always_comb begin
        start_acc  = (state_q == StIdle) && i_start;
        seed_eff   = (i_seed == 32'h0) ? 32'h1 : i_seed;
        len_in_eff = (i_frame_len == '0) ? LenOne : i_frame_len;
        lfsr_src   = start_acc ? seed_eff : lfsr_q;
        len_src    = start_acc ? len_in_eff : len_q;
        beat_lanes = lanes_from(lfsr_src);
        lfsr_next  = lfsr_advance(lfsr_src);
        last_beat  = (beat_cnt_q == len_q - LenOne);
        // A stop arriving together with the final handshake still ends the run.
        stop_now   = stop_pend_q | i_stop;
    end

    // FSM next-state logic and beat loading.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        len_d         = len_q;
        gap_d         = gap_q;
        num_d         = num_q;
        beat_cnt_d    = beat_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        stop_pend_d   = stop_pend_q;
        sof_d         = sof_q;
        tlast_d       = tlast_q;
        tdata_d       = tdata_q;
        frames_sent_d = frames_sent_q;
        load_beat     = 1'b0;
        load_idx      = '0;
        seq_num       = frames_sent_q;

        unique case (state_q)
            StIdle: begin
                // i_stop is ignored here, including when it coincides with i_start.
                if (i_start) begin
                    len_d       = len_in_eff;
                    gap_d       = i_gap;
                    num_d       = i_num_frames;
                    frame_cnt_d = '0;
                    stop_pend_d = 1'b0;
                    state_d     = StSend;
                    load_beat   = 1'b1;
                    load_idx    = '0;
                end
            end

            StSend: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (m_axis_tready) begin
                    if (last_beat) begin
                        frames_sent_d = frames_sent_q + CntOne;
                        frame_cnt_d   = frame_cnt_q + LenOne;
                        if (stop_now ||
                            ((num_q != '0) && (frame_cnt_q + LenOne == num_q))) begin
                            state_d     = StIdle;
                            stop_pend_d = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = StGap;
                            gap_cnt_d = gap_q;
                        end else begin
                            // Back-to-back: next SOF beat follows the TLAST handshake.
                            load_beat = 1'b1;
                            load_idx  = '0;
                            seq_num   = frames_sent_q + CntOne;
                        end
                    end else begin
                        load_beat = 1'b1;
                        load_idx  = beat_cnt_q + LenOne;
                    end
                end
            end

            StGap: begin
                if (i_stop) begin
                    state_d     = StIdle;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == LenOne) begin
                    state_d   = StSend;
                    load_beat = 1'b1;
                    load_idx  = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - LenOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_beat) begin
            lfsr_d     = lfsr_next;
            beat_cnt_d = load_idx;
            tdata_d    = beat_lanes;
            sof_d      = (load_idx == '0);
            tlast_d    = (load_idx == len_src - LenOne);
`ifdef PRBS_FRAME_TX_SEQ_EN
            if (load_idx == '0) begin
                tdata_d[31:0] = 32'(seq_num);
            end
`endif
        end

        tvalid_d = (state_d == StSend);
        busy_d   = (state_d != StIdle);
        // sof/tlast only mean something alongside tvalid; keep them low while idle or gapping.
        if (!tvalid_d) begin
            sof_d   = 1'b0;
            tlast_d = 1'b0;
        end
    end

`ifndef PRBS_FRAME_TX_SEQ_EN
    // Sequence number is only consumed by the optional SOF tagging.
    logic unused_seq;
    assign unused_seq = ^seq_num;
`endif

    // All state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q       <= StIdle;
            lfsr_q        <= 32'h1;
            len_q         <= LenOne;
            gap_q         <= '0;
            num_q         <= '0;
            beat_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            stop_pend_q   <= 1'b0;
            tvalid_q      <= 1'b0;
            sof_q         <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
            busy_q        <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            len_q         <= len_d;
            gap_q         <= gap_d;
            num_q         <= num_d;
            beat_cnt_q    <= beat_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            stop_pend_q   <= stop_pend_d;
            tvalid_q      <= tvalid_d;
            sof_q         <= sof_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
            busy_q        <= busy_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_sof    = sof_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign o_busy        = busy_q;
    assign o_frames_sent = frames_sent_q;

endmodule

// File: tb/tb_prbs_frame_tx.sv
// Directed bench for prbs_frame_tx: a 32-bit and a 64-bit instance share all inputs.
module tb_prbs_frame_tx;

`ifdef PRBS_FRAME_TX_SEQ_EN
    localparam bit SeqEn = 1'b1;
`else
    localparam bit SeqEn = 1'b0;
`endif

    logic        clk;
    logic        i_areset;
    logic        i_start;
    logic        i_stop;
    logic [31:0] i_seed;
    logic [15:0] i_frame_len;
    logic [15:0] i_gap;
    logic [15:0] i_num_frames;
    logic        m_axis_tready;

    logic        vld32, sof32, last32, busy32;
    logic [31:0] data32;
    logic [31:0] frames32;
    logic        vld64, sof64, last64, busy64;
    logic [63:0] data64;
    logic [31:0] frames64;

    int checks = 0;
    int errors = 0;

    // Per-cycle history and accepted-beat lists filled by capture().
    logic        h_vld  [64];
    logic        h_rdy  [64];
    logic        h_sof  [64];
    logic        h_last [64];
    logic        h_busy [64];
    logic [31:0] h_data [64];
    logic [63:0] h_d64  [64];
    logic [31:0] acc_data [$];
    logic        acc_sof  [$];
    logic        acc_last [$];
    int          acc_cyc  [$];

    prbs_frame_tx #(.DATA_WIDTH(32), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut32 (
        .i_aclk        (clk),
        .i_areset      (i_areset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_seed        (i_seed),
        .i_frame_len   (i_frame_len),
        .i_gap         (i_gap),
        .i_num_frames  (i_num_frames),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (vld32),
        .m_axis_sof    (sof32),
        .m_axis_tlast  (last32),
        .m_axis_tdata  (data32),
        .o_busy        (busy32),
        .o_frames_sent (frames32)
    );

    prbs_frame_tx #(.DATA_WIDTH(64), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut64 (
        .i_aclk        (clk),
        .i_areset      (i_areset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_seed        (i_seed),
        .i_frame_len   (i_frame_len),
        .i_gap         (i_gap),
        .i_num_frames  (i_num_frames),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (vld64),
        .m_axis_sof    (sof64),
        .m_axis_tlast  (last64),
        .m_axis_tdata  (data64),
        .o_busy        (busy64),
        .o_frames_sent (frames64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        i_areset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_areset = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] seed, input logic [15:0] len,
                             input logic [15:0] gap, input logic [15:0] num,
                             input logic with_stop);
        @(negedge clk);
        i_seed       = seed;
        i_frame_len  = len;
        i_gap        = gap;
        i_num_frames = num;
        i_start      = 1'b1;
        i_stop       = with_stop;
        @(negedge clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    // Runs a fixed number of cycles; inputs change and outputs are sampled on negedges.
    task automatic capture(input int cycles, input logic [3:0] rdy_pat,
                           input int stop_cyc, input int start_cyc);
        acc_data.delete();
        acc_sof.delete();
        acc_last.delete();
        acc_cyc.delete();
        for (int c = 0; c < cycles; c++) begin
            m_axis_tready = rdy_pat[c % 4];
            i_stop        = (c == stop_cyc);
            i_start       = (c == start_cyc);
            h_vld[c]  = vld32;
            h_rdy[c]  = m_axis_tready;
            h_sof[c]  = sof32;
            h_last[c] = last32;
            h_busy[c] = busy32;
            h_data[c] = data32;
            h_d64[c]  = data64;
            if (vld32 && m_axis_tready) begin
                acc_data.push_back(data32);
                acc_sof.push_back(sof32);
                acc_last.push_back(last32);
                acc_cyc.push_back(c);
            end
            @(negedge clk);
        end
        i_stop        = 1'b0;
        i_start       = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({vld32, sof32, last32, busy32} !== 4'b0 || data32 !== 32'h0 || frames32 !== 32'h0) begin
            errors++;
            $display("FAIL reset32: vld/sof/last/busy=%b data=%h frames=%0d want all 0",
                     {vld32, sof32, last32, busy32}, data32, frames32);
        end
        checks++;
        if ({vld64, sof64, last64, busy64} !== 4'b0 || data64 !== 64'h0 || frames64 !== 32'h0) begin
            errors++;
            $display("FAIL reset64: vld/sof/last/busy=%b data=%h frames=%0d want all 0",
                     {vld64, sof64, last64, busy64}, data64, frames64);
        end
        i_areset = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [31:0] exp_d [4];
        exp_d = '{(SeqEn ? 32'h0 : 32'h1), 32'h3, 32'h6, 32'hD};
        apply_reset();
        start_run(32'h1, 16'd4, 16'd0, 16'd1, 1'b0);
        capture(12, 4'b1111, -1, -1);
        checks++;
        if (acc_data.size() != 4) begin
            errors++;
            $display("FAIL single_count: beats=%0d want 4", acc_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_data[i] !== exp_d[i] || acc_sof[i] !== (i == 0) ||
                    acc_last[i] !== (i == 3) || acc_cyc[i] != i) begin
                    errors++;
                    $display("FAIL single_beat%0d: data=%h sof=%b last=%b cyc=%0d want %h %b %b %0d",
                             i, acc_data[i], acc_sof[i], acc_last[i], acc_cyc[i], exp_d[i],
                             (i == 0), (i == 3), i);
                end
            end
        end
        checks++;
        if (h_vld[4] !== 1'b0 || busy32 !== 1'b0 || frames32 !== 32'd1) begin
            errors++;
            $display("FAIL single_end: vld4=%b busy=%b frames=%0d want 0 0 1",
                     h_vld[4], busy32, frames32);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4];
        int          stalls;
        exp_d = '{(SeqEn ? 32'h0 : 32'h1), 32'h3, 32'h6, 32'hD};
        stalls = 0;
        apply_reset();
        start_run(32'h1, 16'd4, 16'd0, 16'd1, 1'b0);
        capture(20, 4'b1001, -1, -1);
        checks++;
        if (acc_data.size() != 4) begin
            errors++;
            $display("FAIL bp_count: beats=%0d want 4", acc_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_data[i] !== exp_d[i] || acc_sof[i] !== (i == 0) ||
                    acc_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: data=%h sof=%b last=%b want %h %b %b",
                             i, acc_data[i], acc_sof[i], acc_last[i], exp_d[i],
                             (i == 0), (i == 3));
                end
            end
        end
        for (int c = 1; c < 20; c++) begin
            if (h_vld[c-1] && !h_rdy[c-1]) begin
                stalls++;
                checks++;
                if (h_vld[c] !== 1'b1 || h_data[c] !== h_data[c-1] ||
                    h_sof[c] !== h_sof[c-1] || h_last[c] !== h_last[c-1]) begin
                    errors++;
                    $display("FAIL bp_hold_c%0d: vld=%b data=%h sof=%b last=%b want 1 %h %b %b",
                             c, h_vld[c], h_data[c], h_sof[c], h_last[c], h_data[c-1],
                             h_sof[c-1], h_last[c-1]);
                end
            end
        end
        checks++;
        if (stalls < 4 || frames32 !== 32'd1) begin
            errors++;
            $display("FAIL bp_end: stalls=%0d frames=%0d want >=4 1", stalls, frames32);
        end
    endtask

    task automatic test_gap();
        apply_reset();
        start_run(32'h1, 16'd2, 16'd3, 16'd2, 1'b0);
        capture(20, 4'b1111, -1, -1);
        checks++;
        if (acc_data.size() != 4) begin
            errors++;
            $display("FAIL gap_count: beats=%0d want 4", acc_data.size());
        end else begin
            checks++;
            if (acc_last[1] !== 1'b1 || acc_sof[2] !== 1'b1 || acc_cyc[2] - acc_cyc[1] - 1 != 3) begin
                errors++;
                $display("FAIL gap_len: last1=%b sof2=%b idle=%0d want 1 1 3",
                         acc_last[1], acc_sof[2], acc_cyc[2] - acc_cyc[1] - 1);
            end
            checks++;
            if (acc_data[2] !== (SeqEn ? 32'h1 : 32'h6) || acc_data[3] !== 32'hD) begin
                errors++;
                $display("FAIL gap_frame1: data=%h,%h want %h,%h", acc_data[2], acc_data[3],
                         (SeqEn ? 32'h1 : 32'h6), 32'hD);
            end
        end
        checks++;
        if (frames32 !== 32'd2 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL gap_end: frames=%0d busy=%b want 2 0", frames32, busy32);
        end
    endtask

    task automatic test_stop();
        apply_reset();
        start_run(32'h1, 16'd8, 16'd0, 16'd0, 1'b0);
        // A start pulse mid-run with a different length must be ignored.
        i_frame_len = 16'd2;
        capture(32, 4'b1111, 19, 10);
        checks++;
        if (acc_data.size() != 24) begin
            errors++;
            $display("FAIL stop_count: beats=%0d want 24", acc_data.size());
        end else begin
            checks++;
            if (acc_last[23] !== 1'b1 || acc_cyc[23] != 23 || acc_last[7] !== 1'b1) begin
                errors++;
                $display("FAIL stop_last: last23=%b cyc23=%0d last7=%b want 1 23 1",
                         acc_last[23], acc_cyc[23], acc_last[7]);
            end
            checks++;
            if (acc_sof[8] !== 1'b1 || acc_cyc[8] != 8 || acc_sof[16] !== 1'b1 ||
                acc_data[8] !== (SeqEn ? 32'h1 : 32'h1B6)) begin
                errors++;
                $display("FAIL stop_b2b: sof8=%b cyc8=%0d sof16=%b data8=%h want 1 8 1 %h",
                         acc_sof[8], acc_cyc[8], acc_sof[16], acc_data[8],
                         (SeqEn ? 32'h1 : 32'h1B6));
            end
        end
        checks++;
        if (h_vld[24] !== 1'b0 || h_busy[24] !== 1'b0 || frames32 !== 32'd3) begin
            errors++;
            $display("FAIL stop_end: vld24=%b busy24=%b frames=%0d want 0 0 3",
                     h_vld[24], h_busy[24], frames32);
        end
    endtask

    task automatic test_stop_in_gap();
        apply_reset();
        // Start and stop together while idle: start wins.
        start_run(32'h1, 16'd1, 16'd5, 16'd0, 1'b1);
        capture(8, 4'b1111, 2, -1);
        checks++;
        if (acc_data.size() != 1 || acc_sof[0] !== 1'b1 || acc_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL gapstop_beats: beats=%0d want 1 with sof=last=1", acc_data.size());
        end
        checks++;
        if (h_busy[2] !== 1'b1 || h_busy[3] !== 1'b0 || frames32 !== 32'd1) begin
            errors++;
            $display("FAIL gapstop_end: busy2=%b busy3=%b frames=%0d want 1 0 1",
                     h_busy[2], h_busy[3], frames32);
        end
    endtask

    task automatic test_wide();
        logic [63:0] exp0;
        exp0 = {32'h3, (SeqEn ? 32'h0 : 32'h1)};
        apply_reset();
        start_run(32'h1, 16'd4, 16'd0, 16'd1, 1'b0);
        capture(8, 4'b1111, -1, -1);
        checks++;
        if (h_d64[0] !== exp0 || h_d64[1] !== 64'h0000000D_00000006) begin
            errors++;
            $display("FAIL wide_beats: b0=%h b1=%h want %h %h", h_d64[0], h_d64[1], exp0,
                     64'h0000000D_00000006);
        end
        checks++;
        if (busy64 !== 1'b0 || frames64 !== 32'd1) begin
            errors++;
            $display("FAIL wide_end: busy=%b frames=%0d want 0 1", busy64, frames64);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        start_run(32'h1, 16'd8, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        i_areset = 1'b1;
        #1;
        checks++;
        if ({vld32, sof32, last32, busy32} !== 4'b0 || data32 !== 32'h0 || frames32 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_out: vld/sof/last/busy=%b data=%h frames=%0d want all 0",
                     {vld32, sof32, last32, busy32}, data32, frames32);
        end
        @(negedge clk);
        i_areset = 1'b0;
        start_run(32'h0, 16'd0, 16'd0, 16'd2, 1'b0);
        capture(6, 4'b1111, -1, -1);
        checks++;
        if (acc_data.size() != 2) begin
            errors++;
            $display("FAIL midrst_count: beats=%0d want 2", acc_data.size());
        end else begin
            checks++;
            if (acc_data[0] !== (SeqEn ? 32'h0 : 32'h1) || acc_sof[0] !== 1'b1 ||
                acc_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL midrst_beat0: data=%h sof=%b last=%b want %h 1 1",
                         acc_data[0], acc_sof[0], acc_last[0], (SeqEn ? 32'h0 : 32'h1));
            end
            checks++;
            if (acc_data[1] !== (SeqEn ? 32'h1 : 32'h3) || acc_sof[1] !== 1'b1 ||
                acc_last[1] !== 1'b1 || acc_cyc[1] != 1) begin
                errors++;
                $display("FAIL midrst_beat1: data=%h sof=%b last=%b cyc=%0d want %h 1 1 1",
                         acc_data[1], acc_sof[1], acc_last[1], acc_cyc[1],
                         (SeqEn ? 32'h1 : 32'h3));
            end
        end
        checks++;
        if (frames32 !== 32'd2 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_end: frames=%0d busy=%b want 2 0", frames32, busy32);
        end
    endtask

    initial begin
        i_areset      = 1'b1;
        i_start       = 1'b0;
        i_stop        = 1'b0;
        i_seed        = 32'h0;
        i_frame_len   = 16'd0;
        i_gap         = 16'd0;
        i_num_frames  = 16'd0;
        m_axis_tready = 1'b1;

        test_reset();
        test_single_frame();
        test_backpressure();
        test_gap();
        test_stop();
        test_stop_in_gap();
        test_wide();
        test_reset_mid_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
